mul16_iter: RTL and testbench

Iterative 16×16 → 32-bit multiplier for the dynamic pipeline's EX stage. It performs radix-2 shift-and-add and uses the existing 16-bit carry-lookahead adder to form each partial sum, so it consumes that adder's sum and carry outputs every cycle. It supports signed and unsigned operands, and its busy/done pair lets the pipeline control stall EX while a MULT/MULTU is in flight.

---
 rtl/mul16_iter_pkg.sv | 15 +
 rtl/add16.sv | 58 +++++
 rtl/mul16_iter.sv | 108 ++++++++++
 tb/tb_mul16_iter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mul16_iter_pkg.sv
// Shared definitions for the iterative 16x16 multiplier: state encoding and
// operand/iteration widths.
package mul16_iter_pkg;

  localparam int unsigned MUL_W    = 16;
  localparam int unsigned MUL_ITER = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

endpackage

// File: rtl/add16.sv
// 16-bit carry-lookahead adder built from four 4-bit groups.
// oper=1 subtracts (add1 - add2); ogg is the carry out of the top group.
module add16
  import mul16_iter_pkg::*;
(
  input  logic [MUL_W-1:0] add1,
  input  logic [MUL_W-1:0] add2,
  input  logic             cin,
  input  logic             oper,
  output logic [MUL_W-1:0] sum,
  output logic             ogg
);

  logic [MUL_W-1:0] bx;
  logic [MUL_W-1:0] gen;
  logic [MUL_W-1:0] prop;
  logic [MUL_W-1:0] carry;
  logic [3:0]       grp_g;
  logic [3:0]       grp_p;
  logic [4:0]       grp_c;
  logic             c_run;

  always_comb begin
    bx    = oper ? ~add2 : add2;
    gen   = add1 & bx;
    prop  = add1 ^ bx;
    grp_g = '0;
    grp_p = '1;
    grp_c = '0;
    carry = '0;
    c_run = 1'b0;

    // Group generate/propagate first, then the inter-group lookahead.
    for (int unsigned k = 0; k < 4; k++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        grp_g[k] = gen[4*k+i] | (prop[4*k+i] & grp_g[k]);
        grp_p[k] = grp_p[k] & prop[4*k+i];
      end
    end

    grp_c[0] = oper | cin;
    for (int unsigned k = 0; k < 4; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end

    for (int unsigned k = 0; k < 4; k++) begin
      c_run = grp_c[k];
      for (int unsigned i = 0; i < 4; i++) begin
        carry[4*k+i] = c_run;
        c_run = gen[4*k+i] | (prop[4*k+i] & c_run);
      end
    end

    sum = prop ^ carry;
    ogg = grp_c[4];
  end

endmodule

// File: rtl/mul16_iter.sv
// Iterative radix-2 shift-and-add 16x16->32 multiplier, signed or unsigned,
// with a busy/done handshake for stalling the EX stage.
module mul16_iter
  import mul16_iter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MUL_W-1:0]     a,
  input  logic [MUL_W-1:0]     b,
  input  logic                 is_signed,
  output logic                 busy,
  output logic                 done,
  output logic [2*MUL_W-1:0]   product
);

  mul_state_t state_q, state_d;

  logic [3:0]         count;
  logic [MUL_W-1:0]   hi;
  logic [MUL_W-1:0]   lo;
  logic [MUL_W-1:0]   mcand;
  logic               neg;
  logic               accept;
  logic               last_iter;
  logic [MUL_W-1:0]   mcand_in;
  logic [MUL_W-1:0]   mplier_in;
  logic               neg_in;
  logic [MUL_W-1:0]   addend;
  logic [MUL_W-1:0]   psum;
  logic               pcarry;
  logic [2*MUL_W-1:0] acc;

  assign acc       = {hi, lo};
  assign addend    = lo[0] ? mcand : '0;
  assign last_iter = (count == 4'(MUL_ITER - 1));

  // Operands are converted to magnitudes; 0x8000 stays 0x8000 and is read as 32768.
  always_comb begin
    neg_in    = is_signed & (a[MUL_W-1] ^ b[MUL_W-1]);
    mcand_in  = (is_signed & a[MUL_W-1]) ? (~a + 16'd1) : a;
    mplier_in = (is_signed & b[MUL_W-1]) ? (~b + 16'd1) : b;
  end

  add16 u_add16 (
    .add1 (hi),
    .add2 (addend),
    .cin  (1'b0),
    .oper (1'b0),
    .sum  (psum),
    .ogg  (pcarry)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        accept = start;
        if (start) state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_d = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        accept  = start;
        state_d = start ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        count <= '0;
        hi    <= '0;
        lo    <= mplier_in;
        mcand <= mcand_in;
        neg   <= neg_in;
      end else if (state_q == CALC) begin
        // {cout, sum, lo} >> 1 truncated to 32 bits
        {hi, lo} <= {pcarry, psum, lo[MUL_W-1:1]};
        count    <= count + 4'd1;
      end else if (state_q == FIX) begin
        product <= neg ? (~acc + 32'd1) : acc;
      end
    end
  end

endmodule

// File: tb/tb_mul16_iter.sv
// Directed self-checking bench for mul16_iter: latency, handshake, signed and
// unsigned products, ignored start, back-to-back and mid-operation reset.
module tb_mul16_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] prev_product;

  always #5 clk = ~clk;

  mul16_iter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge: presents a request sampled at the next rising edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic sv);
    a         = av;
    b         = bv;
    is_signed = sv;
    start     = 1'b1;
  endtask

  // Follows an accepted request to its done pulse; returns at the negedge in DONE.
  // inject_k >= 0 pulses start with 7x7 while busy at that cycle.
  task automatic wait_done(input string tag, input logic [31:0] exp, input int inject_k);
    int k;
    logic busy_ok;
    @(negedge clk);
    start   = 1'b0;
    k       = 0;
    busy_ok = 1'b1;
    check({tag, "_hold_k0"}, product, prev_product);
    check({tag, "_done_k0"}, {31'b0, done}, 32'd0);
    while (!done && k < 40) begin
      if (k == inject_k) begin
        a = 16'd7; b = 16'd7; is_signed = 1'b0; start = 1'b1;
      end else if (k == inject_k + 1) begin
        start = 1'b0;
      end
      if (k == 16) check({tag, "_hold_k16"}, product, prev_product);
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'd17);
    check({tag, "_busy_run"}, {31'b0, busy_ok}, 32'd1);
    check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    check({tag, "_product"}, product, exp);
    prev_product = exp;
  endtask

  // Confirms the pulse lasted one cycle and the unit went idle.
  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_done_fall"}, {31'b0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int k;
    logic seen_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    prev_product = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_product", product, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    start_op(16'd3, 16'd5, 1'b0);        wait_done("u_3x5", 32'h0000000F, -1);   check_idle("u_3x5");
    start_op(16'hFFFF, 16'hFFFF, 1'b0);  wait_done("u_max", 32'hFFFE0001, -1);   check_idle("u_max");
    start_op(16'hFFFD, 16'd5, 1'b1);     wait_done("s_m3x5", 32'hFFFFFFF1, -1);  check_idle("s_m3x5");
    start_op(16'd3, 16'hFFFB, 1'b1);     wait_done("s_3xm5", 32'hFFFFFFF1, -1);  check_idle("s_3xm5");
    start_op(16'hFFFF, 16'hFFFF, 1'b1);  wait_done("s_m1xm1", 32'h00000001, -1); check_idle("s_m1xm1");
    start_op(16'h8000, 16'h8000, 1'b1);  wait_done("s_min_sq", 32'h40000000, -1); check_idle("s_min_sq");
    start_op(16'h8000, 16'd1, 1'b1);     wait_done("s_min_x1", 32'hFFFF8000, -1); check_idle("s_min_x1");

    // start during CALC must be dropped, not queued
    start_op(16'd2, 16'd3, 1'b0);        wait_done("ign_start", 32'h00000006, 5);
    check_idle("ign_start");
    repeat (20) begin
      @(negedge clk);
      if (done) check("ign_start_extra_done", {31'b0, done}, 32'd0);
    end

    // back-to-back: new request accepted in the DONE cycle
    start_op(16'hFFFF, 16'd2, 1'b0);     wait_done("b2b_first", 32'h0001FFFE, -1);
    start_op(16'h0100, 16'h0100, 1'b0);  wait_done("b2b_second", 32'h00010000, -1);
    check_idle("b2b_second");

    // reset in the middle of CALC aborts with no done
    start_op(16'd9, 16'd9, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_product", product, 32'h0);
    rst = 1'b0;
    prev_product = 32'h0;
    seen_done = 1'b0;
    k = 0;
    while (k < 25) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      k++;
    end
    check("abort_no_done", {31'b0, seen_done}, 32'd0);
    start_op(16'd3, 16'd5, 1'b0);        wait_done("post_abort", 32'h0000000F, -1);
    check_idle("post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
